// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch and program-load signals between the CPU fetch stage and the instruction memory.
// Latency: n/a (wiring only).
// Backpressure: master holds imem_req/imem_addr until imem_drdy; the load port has none.
interface imem_responder_if;
    import imem_pkg::*;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_drdy;
    logic [WORD_W-1:0] imem_rdata;
    logic              imem_err;
    logic              load_we;
    logic [31:0]       load_addr;
    logic [WORD_W-1:0] load_data;

    modport master (
        output imem_req, imem_addr, load_we, load_addr, load_data,
        input  imem_drdy, imem_rdata, imem_err
    );

    modport slave (
        input  imem_req, imem_addr, load_we, load_addr, load_data,
        output imem_drdy, imem_rdata, imem_err
    );

endinterface

// File: rtl/imem_array.sv
// Program-image storage: one write port, one registered read port, read-before-write, no reset.
// Latency: read data appears one cycle after rd_vld.
// Backpressure: none; rd_dat holds until the next rd_vld.
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              wr_vld,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_dat,
    input  logic              rd_vld,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_dat
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    // Both ports update with non-blocking writes, so a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem_q[wr_addr] <= wr_dat;
        end
        if (rd_vld) begin
            rd_dat <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time and returns the word with an imem_drdy pulse.
// Latency: LATENCY cycles from accept to imem_drdy; LATENCY=1 sustains one word per cycle back-to-back.
// Backpressure: none; the requester holds imem_req/imem_addr until imem_drdy and requests are never aborted.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_responder_if.slave bus
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] SRC_ZERO = 2'd0;
    localparam logic [1:0] SRC_ARR  = 2'd1;
    localparam logic [1:0] SRC_NOP  = 2'd2;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              drdy_q, drdy_d;
    logic              err_q, err_d;
    logic [1:0]        src_q, src_d;
    logic              rd_fire;
    logic [31:0]       rd_addr;
    logic              arr_rd_vld;
    logic              arr_wr_vld;
    logic [WORD_W-1:0] arr_rd_dat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        drdy_d  = 1'b0;
        err_d   = err_q;
        src_d   = src_q;
        rd_fire = 1'b0;
        rd_addr = addr_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (bus.imem_req) begin
                    addr_d = bus.imem_addr;
                    cnt_d  = CNT_INIT;
                    // Single-cycle latency reads straight from the incoming address at the accept edge.
                    if (LATENCY == 1) begin
                        rd_fire = 1'b1;
                        rd_addr = bus.imem_addr;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rd_fire = 1'b1;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rd_fire) begin
            drdy_d = 1'b1;
            err_d  = (rd_addr >= DEPTH_L);
            src_d  = (rd_addr >= DEPTH_L) ? SRC_NOP : SRC_ARR;
        end
    end

    // Full-width compares so out-of-range addresses never alias onto low words.
    assign arr_rd_vld = rst_n && rd_fire && (rd_addr < DEPTH_L);
    assign arr_wr_vld = bus.load_we && (bus.load_addr < DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            drdy_q  <= 1'b0;
            err_q   <= 1'b0;
            src_q   <= SRC_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            drdy_q  <= drdy_d;
            err_q   <= err_d;
            src_q   <= src_d;
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_vld  (arr_wr_vld),
        .wr_addr (bus.load_addr[AW-1:0]),
        .wr_dat  (bus.load_data),
        .rd_vld  (arr_rd_vld),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_dat  (arr_rd_dat)
    );

    // The array has no reset, so the selector decides whether its register is exposed.
    assign bus.imem_drdy  = drdy_q;
    assign bus.imem_err   = err_q;
    assign bus.imem_rdata = (src_q == SRC_ARR) ? arr_rd_dat :
                            (src_q == SRC_NOP) ? NOP : '0;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: four instances with LATENCY 1..4 sharing one load port,
// checked against a word-array reference model plus directed corner-case sequences.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int NDUT  = 4;
    localparam int DEPTH = 1024;

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NDUT-1:0]           req_v;
    logic [NDUT-1:0][31:0]     addr_v;
    logic [NDUT-1:0]           drdy_v;
    logic [NDUT-1:0]           err_v;
    logic [NDUT-1:0][31:0]     rdata_v;
    logic                      load_we;
    logic [31:0]               load_addr;
    logic [31:0]               load_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] bq [$];
    vec_t        vt [10];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        imem_responder_if bus ();
        assign bus.imem_req  = req_v[g];
        assign bus.imem_addr = addr_v[g];
        assign bus.load_we   = load_we;
        assign bus.load_addr = load_addr;
        assign bus.load_data = load_data;
        imem_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (g + 1)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign drdy_v[g]  = bus.imem_drdy;
        assign err_v[g]   = bus.imem_err;
        assign rdata_v[g] = bus.imem_rdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return (a < 32'(DEPTH)) ? mem_m[a[9:0]] : NOP;
    endfunction

    function automatic logic exp_err(input logic [31:0] a);
        return a >= 32'(DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'(DEPTH) + 32'($urandom_range(0, 31));
            1:       return $urandom | 32'h0000_0400;
            2:       return 32'(DEPTH - 1);
            default: return 32'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_we = 1'b0;
        if (a < 32'(DEPTH)) mem_m[a[9:0]] = d;
    endtask

    // Bounded wait for imem_drdy; optionally drops the request and scribbles the address mid-flight.
    task automatic wait_drdy(input int k, input bit drop, output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (drop && c == 1 && !drdy_v[k]) begin
                req_v[k]  = 1'b0;
                addr_v[k] = $urandom;
            end
        end while (!drdy_v[k] && c < 40);
    endtask

    task automatic run_burst(input int k, input bit drop, input string tag);
        int c;
        req_v[k]  = 1'b1;
        addr_v[k] = bq[0];
        for (int i = 0; i < bq.size(); i++) begin
            wait_drdy(k, drop, c);
            check({tag, " latency"}, 32'(c), 32'(k + 1));
            check({tag, " data"}, rdata_v[k], exp_data(bq[i]));
            check({tag, " err"}, 32'(err_v[k]), 32'(exp_err(bq[i])));
            if (i + 1 < bq.size()) addr_v[k] = bq[i + 1];
            else req_v[k] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        int          k;
        int          n;
        bit          drop;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] hold;

        rst_n     = 1'b0;
        req_v     = '0;
        addr_v    = '0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset drdy[%0d]", i), 32'(drdy_v[i]), 32'd0);
            check($sformatf("reset rdata[%0d]", i), rdata_v[i], 32'd0);
            check($sformatf("reset err[%0d]", i), 32'(err_v[i]), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(32'(i), $urandom);
        load(32'd5, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) load(32'(i), 32'h10 + 32'(i));
        load(32'd1023, 32'hCAFE_F00D);
        load(32'd9, 32'h0BAD_F00D);
        load(32'd7, 32'hAAAA_AAAA);
        load(32'd1024, 32'hBAD0_0000);
        load(32'h0001_0000, 32'hBAD1_0000);

        vt[0] = '{1, 32'd5,          32'hDEAD_BEEF, 1'b0};
        vt[1] = '{0, 32'd5,          32'hDEAD_BEEF, 1'b0};
        vt[2] = '{3, 32'd5,          32'hDEAD_BEEF, 1'b0};
        vt[3] = '{1, 32'd1024,       32'h0000_0013, 1'b1};
        vt[4] = '{2, 32'h0000_0405,  32'h0000_0013, 1'b1};
        vt[5] = '{0, 32'hFFFF_FFFF,  32'h0000_0013, 1'b1};
        vt[6] = '{1, 32'd0,          32'h0000_0010, 1'b0};
        vt[7] = '{3, 32'd1023,       32'hCAFE_F00D, 1'b0};
        vt[8] = '{2, 32'd3,          32'h0000_0013, 1'b0};
        vt[9] = '{0, 32'h0001_0000,  32'h0000_0013, 1'b1};
        for (int i = 0; i < 10; i++) begin
            k         = vt[i].k;
            req_v[k]  = 1'b1;
            addr_v[k] = vt[i].addr;
            wait_drdy(k, 1'b0, c);
            req_v[k]  = 1'b0;
            check($sformatf("vec%0d latency", i), 32'(c), 32'(k + 1));
            check($sformatf("vec%0d data", i), rdata_v[k], vt[i].exp_d);
            check($sformatf("vec%0d err", i), 32'(err_v[k]), 32'(vt[i].exp_e));
            @(negedge clk);
            check($sformatf("vec%0d single pulse", i), 32'(drdy_v[k]), 32'd0);
        end

        // LATENCY=1 back-to-back: four consecutive pulses while stepping the address.
        req_v[0]  = 1'b1;
        addr_v[0] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b drdy%0d", i), 32'(drdy_v[0]), 32'd1);
            check($sformatf("b2b data%0d", i), rdata_v[0], 32'h10 + 32'(i));
            if (i < 3) addr_v[0] = 32'(i + 1);
            else req_v[0] = 1'b0;
        end
        @(negedge clk);
        check("b2b drdy end", 32'(drdy_v[0]), 32'd0);

        // Collision at the response-read edge of LATENCY=2: old word comes back.
        req_v[1]  = 1'b1;
        addr_v[1] = 32'd7;
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = 32'd7;
        load_data = 32'h5555_5555;
        @(negedge clk);
        load_we  = 1'b0;
        req_v[1] = 1'b0;
        check("rbw l2 drdy", 32'(drdy_v[1]), 32'd1);
        check("rbw l2 data", rdata_v[1], 32'hAAAA_AAAA);
        mem_m[7] = 32'h5555_5555;
        bq = '{32'd7};
        run_burst(1, 1'b0, "rbw l2 reread");

        // LATENCY=1 reads at the accept edge, so a write on that edge is also not yet visible.
        req_v[0]  = 1'b1;
        addr_v[0] = 32'd7;
        load_we   = 1'b1;
        load_addr = 32'd7;
        load_data = 32'h1234_5678;
        @(negedge clk);
        load_we  = 1'b0;
        req_v[0] = 1'b0;
        check("rbw l1 drdy", 32'(drdy_v[0]), 32'd1);
        check("rbw l1 data", rdata_v[0], 32'h5555_5555);
        mem_m[7] = 32'h1234_5678;
        bq = '{32'd7};
        run_burst(0, 1'b0, "rbw l1 reread");

        // Reset one cycle after accept on LATENCY=4 discards the request.
        req_v[3]  = 1'b1;
        addr_v[3] = 32'd9;
        @(negedge clk);
        rst_n    = 1'b0;
        req_v[3] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rst drdy%0d", i), 32'(drdy_v[3]), 32'd0);
            check($sformatf("rst rdata%0d", i), rdata_v[3], 32'd0);
            @(negedge clk);
        end
        bq = '{32'd5};
        run_burst(3, 1'b0, "post-rst l4");

        // LATENCY=3: request dropped and address scribbled in the second WAIT cycle.
        req_v[2]  = 1'b1;
        addr_v[2] = 32'd9;
        @(negedge clk);
        @(negedge clk);
        req_v[2]  = 1'b0;
        addr_v[2] = 32'd5;
        @(negedge clk);
        check("drop drdy", 32'(drdy_v[2]), 32'd1);
        check("drop data", rdata_v[2], 32'h0BAD_F00D);
        check("drop err", 32'(err_v[2]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("drop idle drdy%0d", i), 32'(drdy_v[2]), 32'd0);
            check($sformatf("drop hold%0d", i), rdata_v[2], 32'h0BAD_F00D);
        end
        bq = '{32'd5};
        run_burst(2, 1'b0, "post-drop l3");

        for (int it = 0; it < 80; it++) begin
            k = $urandom_range(0, NDUT - 1);
            if ($urandom_range(0, 3) == 0) begin
                a = rand_addr();
                d = $urandom;
                load(a, d);
                bq = '{a & 32'(DEPTH - 1)};
                run_burst(k, 1'b0, $sformatf("rnd%0d ld-read", it));
            end else begin
                n = $urandom_range(1, 4);
                bq.delete();
                for (int j = 0; j < n; j++) bq.push_back(rand_addr());
                drop = (n == 1) && (k > 0) && ($urandom_range(0, 1) == 1);
                run_burst(k, drop, $sformatf("rnd%0d burst", it));
                hold = exp_data(bq[bq.size() - 1]);
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check($sformatf("rnd%0d idle drdy", it), 32'(drdy_v[k]), 32'd0);
                    check($sformatf("rnd%0d hold", it), rdata_v[k], hold);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory end of the fetch stage's `imem_*` interface. It stores a word-addressed program image, accepts one fetch request at a time, and returns the instruction word after a fixed, parameterised latency with a one-cycle `imem_drdy` pulse. A separate load port writes the program image at boot and from testbenches. It sits between the CPU fetch stage and the future unified memory system.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words stored; power of two, ≥ 2.
- `LATENCY`, 2: accept-to-`imem_drdy` cycles; legal range 1..15.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req`  in  1  fetch request; held high with `imem_addr` stable until `imem_drdy`.
- `imem_addr`  in  32  word address; the PC increments by 1 per instruction.
- `imem_drdy`  out  1  one-cycle pulse; `imem_rdata` and `imem_err` are valid in this cycle.
- `imem_rdata`  out  32  instruction word; holds its value until the next `imem_drdy`.
- `imem_err`  out  1  high with `imem_drdy` when the address was out of range.
- `load_we`  in  1  program-image write enable.
- `load_addr`  in  32  word address for the load write.
- `load_data`  in  32  word to write.

## Operation
- FSM states (`imem_pkg::state_t`): IDLE, WAIT, RESP.
- IDLE: when `imem_req`=1, latch `imem_addr` into `addr_q` and load `cnt` = LATENCY-1. Go to RESP if LATENCY=1, else to WAIT.
- WAIT: `cnt` decrements each cycle. At the edge where `cnt`=1, read the array at `addr_q` into `imem_rdata`, set `imem_drdy`=1, and go to RESP.
  - With LATENCY=1, the read happens at the accept edge.
- RESP: `imem_drdy`=1 for exactly this cycle.
  - If `imem_req`=1 in this cycle, accept `imem_addr` as a new request using the IDLE rules. This gives back-to-back operation.
  - Otherwise go to IDLE.
- Out-of-range access (`addr_q` ≥ DEPTH_WORDS): `imem_rdata` = `imem_pkg::NOP` (0x0000_0013), `imem_err`=1, array not read.
  - Upper address bits are never truncated or aliased.
- Load port: at every edge with `load_we`=1 and `load_addr` < DEPTH_WORDS, the word is written. Out-of-range writes are silently dropped.
  - The load port is independent of the FSM and is legal in any state.
- Read/write collision, same word at the same edge as the response read: the read returns the old word (read-before-write).
  - A write at any earlier edge is visible to the read.
- `imem_req` dropping while in WAIT: the request is still completed. `imem_drdy` pulses and the FSM then returns to IDLE. Requests are never aborted.
- `imem_addr` changing during WAIT is ignored; `addr_q` is used.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, `cnt`=0, `imem_drdy`=0, `imem_err`=0, `imem_rdata`=0.
  - The array contents are NOT cleared.
  - Reset overrides an in-flight request, which is discarded with no `imem_drdy`.
- Request accepted at edge E: `imem_drdy` is high in the cycle following edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Throughput: one word per LATENCY cycles with `imem_req` held continuously. LATENCY=1 gives one word per cycle.
- `imem_drdy` is never high in two consecutive cycles unless LATENCY=1 with back-to-back requests.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `imem_pkg` holds:
  - `state_t` enum {IDLE, WAIT, RESP};
  - `NOP` localparam 32'h0000_0013;
  - `WORD_W` = 32.
- Sub-module `imem_array`: 1 write port, 1 registered read port, read-before-write, no reset. It maps to block RAM.
- Top level holds the FSM, `cnt`, `addr_q`, range check and output registers.

## Test plan
- Load 0xDEAD_BEEF at word 5. With LATENCY=2, req at addr 5 → `imem_drdy`=1 exactly 2 cycles after accept, `imem_rdata`=0xDEAD_BEEF, `imem_err`=0.
- LATENCY=1, words 0..3 = 0x10..0x13, req held with addr stepping 0,1,2,3 on each `imem_drdy` → drdy high 4 consecutive cycles with data 0x10,0x11,0x12,0x13.
- Req at addr 1024 (DEPTH_WORDS=1024) → `imem_drdy`=1, `imem_rdata`=0x0000_0013, `imem_err`=1. A load to 1024 leaves words 0..1023 unchanged.
- Word 7 = 0xAAAA_AAAA. Req at 7; at the response-read edge, load 0x5555_5555 to 7 → returns 0xAAAA_AAAA. A second req at 7 returns 0x5555_5555.
- `rst_n`=0 one cycle after accept (LATENCY=4) → no `imem_drdy`, `imem_rdata`=0, state IDLE. The array still holds its previously loaded data.
- LATENCY=3: req dropped in cycle 2 of WAIT → `imem_drdy` still pulses once, then IDLE. `imem_rdata` stays stable afterwards until the next pulse.
